// File: rtl/fp_unpack_pipe_if.sv
`default_nettype none
// ==========================================================================
// fp_unpack_pipe_if : operand/result handshake bundle for fp_unpack_pipe
// Rev 1.0
// ==========================================================================
interface fp_unpack_pipe_if #(
    parameter int EXP_W = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             OP_A;
    logic [31:0]             OP_B;
    logic [1:0]              MODE_FP;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sign_a;
    logic                    sign_b;
    logic signed [EXP_W-1:0] exp_a;
    logic signed [EXP_W-1:0] exp_b;
    logic [23:0]             mant_a;
    logic [23:0]             mant_b;
    logic [4:0]              class_a;
    logic [4:0]              class_b;
    logic                    mode_err;

    modport master (
        output in_valid, OP_A, OP_B, MODE_FP, out_ready,
        input  in_ready, out_valid, sign_a, sign_b, exp_a, exp_b,
               mant_a, mant_b, class_a, class_b, mode_err
    );

    modport slave (
        input  in_valid, OP_A, OP_B, MODE_FP, out_ready,
        output in_ready, out_valid, sign_a, sign_b, exp_a, exp_b,
               mant_a, mant_b, class_a, class_b, mode_err
    );
endinterface
`default_nettype wire

// File: rtl/fp_unpack_pipe.sv
`default_nettype none
// ==========================================================================
// fp_unpack_pipe : two-stage half/bfloat16/single operand-pair unpacker
// Rev 1.0
// ==========================================================================
module fp_unpack_pipe #(
    parameter bit FTZ   = 1'b0,
    parameter int EXP_W = 10
) (
    input logic             clk,
    input logic             rst_n,
    fp_unpack_pipe_if.slave bus
);
    localparam logic [4:0] C_CLS_NAN  = 5'b10000;
    localparam logic [4:0] C_CLS_INF  = 5'b01000;
    localparam logic [4:0] C_CLS_NORM = 5'b00100;
    localparam logic [4:0] C_CLS_DEN  = 5'b00010;
    localparam logic [4:0] C_CLS_ZERO = 5'b00001;

    if (EXP_W < 10) begin : g_bad_exp_w
        $error("fp_unpack_pipe: EXP_W must be at least 10");
    end

    // Fraction is kept left-aligned in 23 bits so every format shares one datapath.
    typedef struct packed {
        logic        sgn;
        logic [4:0]  cls;
        logic [7:0]  ef;
        logic [22:0] fr;
        logic [4:0]  lz;
    } s1_op_t;

    typedef struct packed {
        logic                    sgn;
        logic [4:0]              cls;
        logic signed [EXP_W-1:0] e;
        logic [23:0]             m;
    } s2_op_t;

    function automatic logic [4:0] lzc23(input logic [22:0] f);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 22; i >= 0; i--) begin
            if (!found) begin
                if (f[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    function automatic s1_op_t decode(input logic [31:0] x, input logic [1:0] mode);
        s1_op_t o;
        logic   emax;
        logic   ezero;
        logic   fzero;
        o = '0;
        case (mode)
            2'b00: begin
                o.sgn = x[15];
                o.ef  = {3'b000, x[14:10]};
                o.fr  = {x[9:0], 13'd0};
                emax  = &x[14:10];
            end
            2'b01: begin
                o.sgn = x[15];
                o.ef  = x[14:7];
                o.fr  = {x[6:0], 16'd0};
                emax  = &x[14:7];
            end
            default: begin
                o.sgn = x[31];
                o.ef  = x[30:23];
                o.fr  = x[22:0];
                emax  = &x[30:23];
            end
        endcase
        ezero = (o.ef == 8'd0);
        fzero = (o.fr == 23'd0);
        o.lz  = lzc23(o.fr);
        if (ezero && fzero)  o.cls = C_CLS_ZERO;
        else if (ezero)      o.cls = FTZ ? C_CLS_ZERO : C_CLS_DEN;
        else if (emax)       o.cls = fzero ? C_CLS_INF : C_CLS_NAN;
        else                 o.cls = C_CLS_NORM;
        return o;
    endfunction

    function automatic s2_op_t finish(input s1_op_t i, input logic half);
        s2_op_t            o;
        logic signed [9:0] bias;
        logic signed [9:0] e;
        bias  = half ? 10'sd15 : 10'sd127;
        e     = '0;
        o.sgn = i.sgn;
        o.cls = i.cls;
        o.m   = '0;
        case (i.cls)
            C_CLS_NORM: begin
                o.m = {1'b1, i.fr};
                e   = $signed({2'b00, i.ef}) - bias;
            end
            // Denormal: 1 - bias - (lz + 1) collapses to -bias - lz.
            C_CLS_DEN: begin
                o.m = {i.fr, 1'b0} << i.lz;
                e   = -bias - $signed({5'b00000, i.lz});
            end
            C_CLS_INF, C_CLS_NAN: o.m = {1'b0, i.fr};
            default: ;
        endcase
        o.e = EXP_W'(e);
        return o;
    endfunction

    logic   s1_load;
    logic   s2_load;
    logic   v1_q;
    logic   v2_q;
    logic   half1_q;
    logic   merr1_q;
    logic   merr2_q;
    s1_op_t a1_q;
    s1_op_t b1_q;
    s2_op_t a2_q;
    s2_op_t b2_q;

    assign s2_load = !v2_q || bus.out_ready;
    assign s1_load = !v1_q || s2_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            half1_q <= 1'b0;
            merr1_q <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
        end else if (s1_load) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                half1_q <= (bus.MODE_FP == 2'b00);
                merr1_q <= (bus.MODE_FP == 2'b11);
                a1_q    <= decode(bus.OP_A, bus.MODE_FP);
                b1_q    <= decode(bus.OP_B, bus.MODE_FP);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            merr2_q <= 1'b0;
            a2_q    <= '0;
            b2_q    <= '0;
        end else if (s2_load) begin
            v2_q <= v1_q;
            if (v1_q) begin
                merr2_q <= merr1_q;
                a2_q    <= finish(a1_q, half1_q);
                b2_q    <= finish(b1_q, half1_q);
            end
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = v2_q;
    assign bus.mode_err  = merr2_q;
    assign bus.sign_a    = a2_q.sgn;
    assign bus.sign_b    = b2_q.sgn;
    assign bus.exp_a     = a2_q.e;
    assign bus.exp_b     = b2_q.e;
    assign bus.mant_a    = a2_q.m;
    assign bus.mant_b    = b2_q.m;
    assign bus.class_a   = a2_q.cls;
    assign bus.class_b   = b2_q.cls;
endmodule
`default_nettype wire

// File: tb/tb_fp_unpack_pipe.sv
`default_nettype none
// tb_fp_unpack_pipe : directed scoreboard bench for fp_unpack_pipe (FTZ=0 main, FTZ=1 shadow).
module tb_fp_unpack_pipe;
    localparam int EXP_W = 10;
    localparam logic [4:0] NAN = 5'b10000;
    localparam logic [4:0] INF = 5'b01000;
    localparam logic [4:0] NRM = 5'b00100;
    localparam logic [4:0] DEN = 5'b00010;
    localparam logic [4:0] ZRO = 5'b00001;

    typedef struct packed {
        logic                    s;
        logic signed [EXP_W-1:0] e;
        logic [23:0]             m;
        logic [4:0]              c;
    } opr_t;

    typedef struct packed {
        opr_t a;
        opr_t b;
        logic merr;
    } res_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t prev_res;
    logic stall_prev = 1'b0;

    fp_unpack_pipe_if #(.EXP_W(EXP_W)) bus0 ();
    fp_unpack_pipe_if #(.EXP_W(EXP_W)) bus1 ();

    fp_unpack_pipe #(.FTZ(1'b0), .EXP_W(EXP_W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
    fp_unpack_pipe #(.FTZ(1'b1), .EXP_W(EXP_W)) u_ftz (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.OP_A      = bus0.OP_A;
    assign bus1.OP_B      = bus0.OP_B;
    assign bus1.MODE_FP   = bus0.MODE_FP;
    assign bus1.out_ready = bus0.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic opr_t op(input logic s, input int e, input logic [23:0] m, input logic [4:0] c);
        opr_t o;
        o.s = s;
        o.e = EXP_W'(e);
        o.m = m;
        o.c = c;
        return o;
    endfunction

    function automatic res_t mk(input opr_t a, input opr_t b, input logic me);
        res_t r;
        r.a    = a;
        r.b    = b;
        r.merr = me;
        return r;
    endfunction

    function automatic res_t get0();
        return mk(op(bus0.sign_a, int'(bus0.exp_a), bus0.mant_a, bus0.class_a),
                  op(bus0.sign_b, int'(bus0.exp_b), bus0.mant_b, bus0.class_b), bus0.mode_err);
    endfunction

    function automatic res_t get1();
        return mk(op(bus1.sign_a, int'(bus1.exp_a), bus1.mant_a, bus1.class_a),
                  op(bus1.sign_b, int'(bus1.exp_b), bus1.mant_b, bus1.class_b), bus1.mode_err);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                        input res_t expv, output int waits);
        logic acc;
        bus0.MODE_FP  = mode;
        bus0.OP_A     = a;
        bus0.OP_B     = b;
        bus0.in_valid = 1'b1;
        waits = 0;
        acc   = 1'b0;
        while (!acc && waits < 20) begin
            @(negedge clk);
            acc = bus0.in_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        bus0.in_valid = 1'b0;
        if (acc) exp_q.push_back(expv);
        else     chk("accept_timeout", 128'(acc), 128'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    always @(negedge clk) begin : mon
        res_t cur;
        cur = get0();
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) chk("stall_hold", 128'(cur), 128'(prev_res));
            if (bus0.out_valid && bus0.out_ready) begin
                if (exp_q.size() == 0) chk("result_pending", 128'(exp_q.size()), 128'(1));
                else                   chk("result", 128'(cur), 128'(exp_q.pop_front()));
            end
            stall_prev <= bus0.out_valid && !bus0.out_ready;
            prev_res   <= cur;
        end
    end

    initial begin : stim
        int w;
        int tot;
        rst_n          = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.OP_A      = '0;
        bus0.OP_B      = '0;
        bus0.MODE_FP   = 2'b00;
        bus0.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 128'(bus0.out_valid), 128'(0));
        chk("rst_in_ready", 128'(bus0.in_ready), 128'(1));
        chk("rst_data", 128'(get0()), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single 1.0 / -3.0: accepted on first edge, visible two cycles later
        send(2'b10, 32'h3F80_0000, 32'hC040_0000,
             mk(op(0, 0, 24'h800000, NRM), op(1, 1, 24'hC00000, NRM), 0), w);
        chk("first_accept_waits", 128'(w), 128'(1));
        chk("lat_not_yet", 128'(bus0.out_valid), 128'(0));
        @(posedge clk); #1;
        chk("lat_two", 128'(bus0.out_valid), 128'(1));
        drain();

        // half denormals, also checked on the flush-to-zero instance
        send(2'b00, 32'h0000_0001, 32'h0000_8200,
             mk(op(0, -24, 24'h800000, DEN), op(1, -15, 24'h800000, DEN), 0), w);
        @(posedge clk); #1;
        chk("ftz_valid", 128'(bus1.out_valid), 128'(1));
        chk("ftz_result", 128'(get1()),
            128'(mk(op(0, 0, 24'h0, ZRO), op(1, 0, 24'h0, ZRO), 0)));
        drain();

        // back-to-back stream, one pair per cycle
        send(2'b01, 32'h0000_7F80, 32'h0000_7FC1,
             mk(op(0, 0, 24'h000000, INF), op(0, 0, 24'h410000, NAN), 0), w);
        tot = w;
        send(2'b10, 32'h0000_0001, 32'h7F7F_FFFF,
             mk(op(0, -149, 24'h800000, DEN), op(0, 127, 24'hFFFFFF, NRM), 0), w);
        tot += w;
        send(2'b00, 32'hFFFF_7BFF, 32'h0000_8000,
             mk(op(0, 15, 24'hFFE000, NRM), op(1, 0, 24'h000000, ZRO), 0), w);
        tot += w;
        send(2'b11, 32'h3F80_0000, 32'h0080_0000,
             mk(op(0, 0, 24'h800000, NRM), op(0, -126, 24'h800000, NRM), 1), w);
        tot += w;
        send(2'b10, 32'h3F80_0000, 32'h0080_0000,
             mk(op(0, 0, 24'h800000, NRM), op(0, -126, 24'h800000, NRM), 0), w);
        tot += w;
        chk("stream_rate", 128'(tot), 128'(5));
        drain();

        // backpressure: two fill the pipe, the third must wait
        bus0.out_ready = 1'b0;
        send(2'b10, 32'h3F80_0000, 32'h4000_0000,
             mk(op(0, 0, 24'h800000, NRM), op(0, 1, 24'h800000, NRM), 0), w);
        tot = w;
        send(2'b10, 32'h4040_0000, 32'h4080_0000,
             mk(op(0, 1, 24'hC00000, NRM), op(0, 2, 24'h800000, NRM), 0), w);
        tot += w;
        chk("bp_two_accepted", 128'(tot), 128'(2));
        bus0.OP_A     = 32'hC000_0000;
        bus0.OP_B     = 32'h3F00_0000;
        bus0.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", 128'(bus0.in_ready), 128'(0));
        end
        @(posedge clk); #1;
        bus0.out_ready = 1'b1;
        send(2'b10, 32'hC000_0000, 32'h3F00_0000,
             mk(op(1, 1, 24'h800000, NRM), op(0, -1, 24'h800000, NRM), 0), w);
        send(2'b10, 32'h4120_0000, 32'hBF80_0000,
             mk(op(0, 3, 24'hA00000, NRM), op(1, 0, 24'h800000, NRM), 0), w);
        drain();

        // asynchronous reset with two results in flight
        bus0.out_ready = 1'b0;
        send(2'b10, 32'h4000_0000, 32'h4000_0000,
             mk(op(0, 1, 24'h800000, NRM), op(0, 1, 24'h800000, NRM), 0), w);
        send(2'b10, 32'h4080_0000, 32'h4080_0000,
             mk(op(0, 2, 24'h800000, NRM), op(0, 2, 24'h800000, NRM), 0), w);
        @(posedge clk); #3;
        chk("pre_rst_valid", 128'(bus0.out_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", 128'(bus0.out_valid), 128'(0));
        chk("rst_async_in_ready", 128'(bus0.in_ready), 128'(1));
        chk("rst_async_data", 128'(get0()), 128'(0));
        exp_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n          = 1'b1;
        bus0.out_ready = 1'b1;
        send(2'b01, 32'h0000_3F80, 32'h0000_C000,
             mk(op(0, 0, 24'h800000, NRM), op(1, 1, 24'h800000, NRM), 0), w);
        chk("post_rst_accept", 128'(w), 128'(1));
        chk("post_rst_not_yet", 128'(bus0.out_valid), 128'(0));
        @(posedge clk); #1;
        chk("post_rst_valid", 128'(bus0.out_valid), 128'(1));
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", 128'(bus0.out_valid), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp_unpack_pipe.md
FP_UNPACK_PIPE -- requirements
Module: fp_unpack_pipe

Interface
REQ-001 Parameter FTZ, default 0: 1 = denormal inputs flushed to signed zero; 0 = denormals normalised.
REQ-002 Parameter EXP_W, default 10: width of the signed unbiased exponent outputs; legal values are 10 or more.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: an operand pair is presented.
REQ-006 Port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-007 Port OP_A / OP_B, input, 32 bits each: raw operands; 16-bit formats use bits [15:0] and ignore [31:16].
REQ-008 Port MODE_FP, input, 2 bits: 00 = half (1/5/10, bias 15), 01 = bfloat16 (1/8/7, bias 127), 10 = single (1/8/23, bias 127), 11 = reserved.
REQ-009 Port out_valid, output, 1 bit: the result is valid.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port sign_a / sign_b, output, 1 bit each: operand signs.
REQ-012 Port exp_a / exp_b, output, EXP_W bits each, signed: unbiased exponent.
REQ-013 Port mant_a / mant_b, output, 24 bits each: significand with the leading 1 at bit 23.
REQ-014 Port class_a / class_b, output, 5 bits each, one-hot: {nan, inf, normal, denormal, zero} from bit 4 down to bit 0.
REQ-015 Port mode_err, output, 1 bit: the result came from MODE_FP = 11.

Function
REQ-016 The block SHALL be a two-stage pipeline. S1 registers: field extraction, classification, leading-zero count. S2 registers: normalising shift and exponent compute.
REQ-017 A pair SHALL be accepted on a cycle where in_valid & in_ready; a result SHALL be consumed on a cycle where out_valid & out_ready.
REQ-018 Stage S2 SHALL load when S2 is empty or out_ready = 1; stage S1 SHALL load when S1 is empty or S2 loads.
REQ-019 in_ready SHALL equal that S1 load condition, combinationally; there is no other path from out_ready to in_ready.
REQ-020 With out_ready held at 1, latency SHALL be 2 cycles from acceptance to out_valid, and throughput SHALL be one pair per cycle.
REQ-021 Outputs SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-022 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-023 Classification per operand, with E = exponent field and F = fraction field:
- E = 0 and F = 0: zero.
- E = 0 and F != 0: denormal.
- E all ones and F = 0: inf.
- E all ones and F != 0: nan.
- otherwise: normal.
REQ-024 Normal operand: mant = {1, F left-aligned to bits [22:0], zero-filled}; exp = E - bias.
REQ-025 Denormal operand with FTZ = 0: let lz = leading zeros of F within its format width. mant = F shifted so its MSB lands on bit 23; exp = 1 - bias - (lz + 1).
REQ-026 Denormal operand with FTZ = 1: class = zero, mant = 0, exp = 0, sign preserved.
REQ-027 Zero, inf and nan operands: exp = 0. Zero has mant = 0. Inf and nan have mant = {0, F left-aligned in [22:0]}, so mant[22] is the quiet bit.
REQ-028 The exponent SHALL be sign-extended to EXP_W; no overflow is possible, since the range is -149..127.
REQ-029 MODE_FP = 11 SHALL decode as single and set mode_err for that result only.
REQ-030 MODE_FP SHALL be captured with the operands at acceptance; a change after acceptance SHALL NOT affect in-flight results.

Reset
REQ-031 While rst_n = 0, out_valid and both stage valids SHALL be 0 immediately (asynchronous), regardless of the clock.
REQ-032 While rst_n = 0, all data outputs SHALL be 0 and in_ready SHALL be 1.
REQ-033 Data in flight when reset asserts SHALL be discarded.
REQ-034 The first acceptance SHALL be possible on the first rising clk edge with rst_n = 1.

Verification
REQ-035 Single mode, OP_A = 0x3F800000, OP_B = 0xC0400000, out_ready = 1. Required two cycles later: out_valid = 1; A: sign 0, exp 0, mant 0x800000, class normal; B: sign 1, exp 1, mant 0xC00000, class normal.
REQ-036 Half mode, FTZ = 0, OP_A = 0x0001, OP_B = 0x8200. Required: A: exp -24, mant 0x800000, class denormal; B: sign 1, exp -15, mant 0x800000, class denormal. Repeat with FTZ = 1: both class zero, exp 0, mant 0, signs 0 and 1.
REQ-037 bfloat16 mode, OP_A = 0x7F80, OP_B = 0x7FC1. Required: A class inf, mant 0; B class nan, mant 0x410000 (bit 22 set).
REQ-038 Backpressure: out_ready = 0 while driving in_valid = 1 with 4 consecutive pairs. Required: exactly 2 accepted, then in_ready = 0. After out_ready = 1, all results emerge in order with no loss and stable outputs during the stall.
REQ-039 Assert rst_n = 0 mid-clock with 2 results in flight. Required: out_valid = 0 before the next clk edge. After release, a new pair appears after 2 cycles with no stale data.
REQ-040 MODE_FP = 11 with OP_A = 0x3F800000. Required: mode_err = 1, A decoded as single 1.0. The following pair with MODE_FP = 10 has mode_err = 0.
